// File: rtl/oam_port_arbiter.sv
// Arbitrates the single-port OAM RAM between the sprite scanner (reads) and the host (reads/writes).
// state   | meaning
// IDLE    | grant decision; host writes complete here without leaving IDLE
// SCAN_RD | scanner read in flight, waiting out RAM latency
// HOST_RD | host read in flight, waiting out RAM latency
module oam_port_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int HOST_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              scan_active,
  input  logic              scan_read,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_avail,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SV_W = $clog2(HOST_MAX + 1);

  typedef enum logic [1:0] {IDLE, SCAN_RD, HOST_RD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              clr_seen;
  logic              wr_ack_q;
  logic [SV_W-1:0]   starve;
  logic [DATA_W-1:0] scan_data_q, host_rdata_q;
  logic              host_elig, scan_elig, grant_host, grant_scan, rd_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      pend         <= 1'b0;
      pend_addr    <= '0;
      clr_seen     <= 1'b0;
      wr_ack_q     <= 1'b0;
      starve       <= '0;
      scan_overrun <= 1'b0;
      scan_data_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_ack_q <= grant_host && host_we;
      clr_seen <= (state == SCAN_RD) && !rd_done && (clr_seen || clear);
      if (scan_read && pend && !grant_scan && !clear)
        scan_overrun <= 1'b1;
      // A granted pending entry frees the latch for a same-cycle scan_read.
      if (clear) begin
        pend <= 1'b0;
      end else if (grant_scan) begin
        pend <= pend && scan_read;
        if (pend && scan_read) pend_addr <= scan_addr;
      end else if (scan_read && !pend) begin
        pend      <= 1'b1;
        pend_addr <= scan_addr;
      end
      if (!host_req || grant_host)
        starve <= '0;
      else if (grant_scan && starve != SV_W'(HOST_MAX))
        starve <= starve + SV_W'(1);
      if (scan_avail) scan_data_q <= ram_rdata;
      if (state == HOST_RD && rd_done) host_rdata_q <= ram_rdata;
    end
  end

  always_comb begin
    rd_done    = (cnt == 2'd0);
    // A host write is still acknowledging while host_req is high; keep it from re-granting.
    host_elig  = host_req && !wr_ack_q && !reset;
    scan_elig  = (pend || scan_read) && !clear && !reset;
    grant_host = 1'b0;
    grant_scan = 1'b0;
    if (state == IDLE) begin
      if (scan_active) begin
        if (host_elig && starve == SV_W'(HOST_MAX)) grant_host = 1'b1;
        else if (scan_elig)                         grant_scan = 1'b1;
        else if (host_elig)                         grant_host = 1'b1;
      end else begin
        if (host_elig)      grant_host = 1'b1;
        else if (scan_elig) grant_scan = 1'b1;
      end
    end

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_scan) begin
          state_nxt = SCAN_RD;
          cnt_nxt   = 2'(RD_LAT - 1);
        end else if (grant_host && !host_we) begin
          state_nxt = HOST_RD;
          cnt_nxt   = 2'(RD_LAT - 1);
        end
      end
      SCAN_RD, HOST_RD: begin
        if (rd_done) state_nxt = IDLE;
        else         cnt_nxt   = cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase

    ram_en    = grant_host || grant_scan;
    ram_we    = grant_host && host_we;
    ram_addr  = '0;
    if (grant_host)      ram_addr = host_addr;
    else if (grant_scan) ram_addr = pend ? pend_addr : scan_addr;
    ram_wdata = (grant_host && host_we) ? host_wdata : '0;

    scan_avail = (state == SCAN_RD) && rd_done && !clr_seen && !clear;
    host_ack   = wr_ack_q || ((state == HOST_RD) && rd_done);
    scan_data  = scan_avail ? ram_rdata : scan_data_q;
    host_rdata = ((state == HOST_RD) && rd_done) ? ram_rdata : host_rdata_q;
  end

endmodule
